gpr_scoreboard: RTL and testbench
=================================

Name: gpr_scoreboard

Overview:
- Data hazard control unit of the in-order pipeline, between decode/operand fetch and issue.
- Consumes the decode-side hazard request: source/destination GPRs, CR field masks, CTR/LNK/XER read/write flags.
- Holds one pending-write bit per tracked resource and stalls issue on RAW or WAW conflicts.
- Clears pending bits when the ALU and memory writeback ports retire results.

Parameters:
- NUM_GPR, 32, number of general purpose registers; index width is clog2(NUM_GPR).
- NUM_CR, 8, number of condition register fields.
- WB_BYPASS, 1, when 1 a resource retiring this cycle is not counted as pending for this cycle's hazard check.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- en  in  1  issue enable from inst fetch; when 0, no issue and no pending bits are set
- issue_valid  in  1  decode presents an instruction
- issue_ready  out  1  no hazard, en=1, reset=0 (combinational)
- stall  out  1  issue_valid & ~issue_ready
- gpr_a, gpr_b, gpr_c  in  5 each  source GPR indices
- read_gpr_a, read_gpr_b, read_gpr_c  in  1 each  source enables
- gpr_dest_alu, gpr_dest_mem  in  5 each  destination GPR indices
- write_gpr_dest_alu, write_gpr_dest_mem  in  1 each  destination enables
- read_cr  in  8  OR of the decode CR read masks
- write_cr  in  8  CR field write mask
- read_ctr, write_ctr, read_lnk, write_lnk, read_xer, write_xer  in  1 each  SPR read/write flags
- wb_alu_valid  in  1  ALU writeback; wb_alu_gpr  in  5  its register
- wb_mem_valid  in  1  memory writeback; wb_mem_gpr  in  5  its register
- wb_cr  in  8  CR fields retired this cycle
- wb_ctr, wb_lnk, wb_xer  in  1 each  SPR retired this cycle
- busy  out  1  any pending bit set (registered)
- err  out  1  sticky; set on a writeback to a non-pending resource

Behaviour:
- The clock and reset are fixed: one clock, clk; reset is synchronous and active-high, named reset.
- Reset: all pending bits 0, busy=0, err=0. While reset=1, issue_ready=0 and stall=issue_valid.
- Reset mid-operation: all pending state is discarded in that edge; in-flight writebacks after reset raise err.
- Effective pending: eff_p[r] = p[r] & ~(WB_BYPASS & retire[r]).
- A GPR retires when (wb_alu_valid & wb_alu_gpr==r) | (wb_mem_valid & wb_mem_gpr==r). CR, CTR, LNK and XER retire analogously.
- RAW hazard: any enabled source has eff_p set. Covers gpr_a/b/c, read_cr & eff_p_cr != 0, and read_ctr/lnk/xer.
- WAW hazard: any enabled destination has eff_p set. Covers GPR dest alu/mem, write_cr & eff_p_cr, and the CTR/LNK/XER write flags.
- issue_ready = en & ~reset & ~RAW & ~WAW. Latency is 0 cycles: combinational from inputs and state.
- issue_fire = issue_valid & issue_ready. On fire, every enabled destination's pending bit is set at the next edge.
- Per-bit next state is p' = (p & ~retire) | set. Set dominates when a retire and a set of the same resource coincide.
- Both wb ports naming the same pending GPR in one cycle: cleared once, no err.
- Writeback to a resource with p=0 sets err; the bit stays 0. err clears only on reset.
- Register 0 is tracked like any other GPR; there is no hardwired-zero special case.
- gpr_dest_alu == gpr_dest_mem with both enables set is unsupported. The single bit is cleared by the first writeback. Flag it with a bench assertion.
- When en=0 or issue_valid=0, hazard outputs still evaluate, but no bits are set.
- busy is registered from the next-state OR of all pending bits.

Test Plan:
- Reset: assert reset with issue_valid=1 -> issue_ready=0, stall=1. Deassert -> busy=0, err=0; an issue with src r3 gives issue_ready=1.
- RAW GPR: fire write_gpr_dest_alu r5; next cycle read_gpr_a r5 -> stall=1. wb_alu_valid r5 that cycle with WB_BYPASS=1 -> issue_ready=1 same cycle; with WB_BYPASS=0 -> ready one cycle later.
- WAW plus set-dominates: pending r7, wb_mem r7 in the same cycle a new write to r7 fires -> p[7]=1 afterwards, busy=1.
- CR/SPR: fire write_cr=0x04 and write_ctr. read_cr=0x02 -> ready. read_cr=0x04 -> stall. read_ctr -> stall until wb_ctr. wb_cr=0x04 then clears busy.
- Error path: wb_alu_valid r9 with p[9]=0 -> err=1 next cycle and stays 1. Dual-port retire of pending r4 on both ports -> p[4]=0, no new err.
- en gating: en=0, issue_valid=1, no hazards -> issue_ready=0, no pending bits set, busy unchanged.

Source files
------------

// File: rtl/gpr_scoreboard.sv
// Data hazard scoreboard between operand fetch and issue: one pending-write bit per
// GPR, CR field, CTR, LNK and XER. Issue is stalled on RAW/WAW conflicts.
module gpr_scoreboard #(
  parameter int NUM_GPR   = 32,
  parameter int NUM_CR    = 8,
  parameter int WB_BYPASS = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        en,
  input  logic                        issue_valid,
  output logic                        issue_ready,
  output logic                        stall,
  input  logic [$clog2(NUM_GPR)-1:0]  gpr_a,
  input  logic [$clog2(NUM_GPR)-1:0]  gpr_b,
  input  logic [$clog2(NUM_GPR)-1:0]  gpr_c,
  input  logic                        read_gpr_a,
  input  logic                        read_gpr_b,
  input  logic                        read_gpr_c,
  input  logic [$clog2(NUM_GPR)-1:0]  gpr_dest_alu,
  input  logic [$clog2(NUM_GPR)-1:0]  gpr_dest_mem,
  input  logic                        write_gpr_dest_alu,
  input  logic                        write_gpr_dest_mem,
  input  logic [NUM_CR-1:0]           read_cr,
  input  logic [NUM_CR-1:0]           write_cr,
  input  logic                        read_ctr,
  input  logic                        write_ctr,
  input  logic                        read_lnk,
  input  logic                        write_lnk,
  input  logic                        read_xer,
  input  logic                        write_xer,
  input  logic                        wb_alu_valid,
  input  logic [$clog2(NUM_GPR)-1:0]  wb_alu_gpr,
  input  logic                        wb_mem_valid,
  input  logic [$clog2(NUM_GPR)-1:0]  wb_mem_gpr,
  input  logic [NUM_CR-1:0]           wb_cr,
  input  logic                        wb_ctr,
  input  logic                        wb_lnk,
  input  logic                        wb_xer,
  output logic                        busy,
  output logic                        err
);

  localparam int IDX_W = $clog2(NUM_GPR);
  localparam bit BYP   = (WB_BYPASS != 0);

  logic [NUM_GPR-1:0] p_gpr_q, p_gpr_d;
  logic [NUM_CR-1:0]  p_cr_q, p_cr_d;
  logic               p_ctr_q, p_ctr_d;
  logic               p_lnk_q, p_lnk_d;
  logic               p_xer_q, p_xer_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;

  logic [NUM_GPR-1:0] retire_gpr, set_gpr, eff_gpr;
  logic [NUM_CR-1:0]  set_cr, eff_cr;
  logic               set_ctr, set_lnk, set_xer;
  logic               eff_ctr, eff_lnk, eff_xer;
  logic               raw, waw, fire, wb_err;

  always_comb begin
    retire_gpr = '0;
    for (int i = 0; i < NUM_GPR; i++) begin
      retire_gpr[i] = (wb_alu_valid && (wb_alu_gpr == IDX_W'(i))) ||
                      (wb_mem_valid && (wb_mem_gpr == IDX_W'(i)));
    end

    // A resource retiring this cycle is treated as already free when bypass is on.
    eff_gpr = p_gpr_q & ~(retire_gpr & {NUM_GPR{BYP}});
    eff_cr  = p_cr_q  & ~(wb_cr & {NUM_CR{BYP}});
    eff_ctr = p_ctr_q & ~(wb_ctr & BYP);
    eff_lnk = p_lnk_q & ~(wb_lnk & BYP);
    eff_xer = p_xer_q & ~(wb_xer & BYP);

    raw = (read_gpr_a && eff_gpr[gpr_a]) ||
          (read_gpr_b && eff_gpr[gpr_b]) ||
          (read_gpr_c && eff_gpr[gpr_c]) ||
          (|(read_cr & eff_cr)) ||
          (read_ctr && eff_ctr) ||
          (read_lnk && eff_lnk) ||
          (read_xer && eff_xer);

    waw = (write_gpr_dest_alu && eff_gpr[gpr_dest_alu]) ||
          (write_gpr_dest_mem && eff_gpr[gpr_dest_mem]) ||
          (|(write_cr & eff_cr)) ||
          (write_ctr && eff_ctr) ||
          (write_lnk && eff_lnk) ||
          (write_xer && eff_xer);

    issue_ready = en && !reset && !raw && !waw;
    stall       = issue_valid && !issue_ready;
    fire        = issue_valid && issue_ready;

    set_gpr = '0;
    if (fire && write_gpr_dest_alu) set_gpr[gpr_dest_alu] = 1'b1;
    if (fire && write_gpr_dest_mem) set_gpr[gpr_dest_mem] = 1'b1;
    set_cr  = fire ? write_cr : '0;
    set_ctr = fire && write_ctr;
    set_lnk = fire && write_lnk;
    set_xer = fire && write_xer;

    // Set is OR'ed after the clear so a same-cycle reissue keeps the bit pending.
    p_gpr_d = (p_gpr_q & ~retire_gpr) | set_gpr;
    p_cr_d  = (p_cr_q  & ~wb_cr)      | set_cr;
    p_ctr_d = (p_ctr_q & ~wb_ctr)     | set_ctr;
    p_lnk_d = (p_lnk_q & ~wb_lnk)     | set_lnk;
    p_xer_d = (p_xer_q & ~wb_xer)     | set_xer;

    wb_err = (wb_alu_valid && !p_gpr_q[wb_alu_gpr]) ||
             (wb_mem_valid && !p_gpr_q[wb_mem_gpr]) ||
             (|(wb_cr & ~p_cr_q)) ||
             (wb_ctr && !p_ctr_q) ||
             (wb_lnk && !p_lnk_q) ||
             (wb_xer && !p_xer_q);

    err_d  = err_q || wb_err;
    busy_d = (|p_gpr_d) || (|p_cr_d) || p_ctr_d || p_lnk_d || p_xer_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      p_gpr_q <= '0;
      p_cr_q  <= '0;
      p_ctr_q <= 1'b0;
      p_lnk_q <= 1'b0;
      p_xer_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      p_gpr_q <= p_gpr_d;
      p_cr_q  <= p_cr_d;
      p_ctr_q <= p_ctr_d;
      p_lnk_q <= p_lnk_d;
      p_xer_q <= p_xer_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign busy = busy_q;
  assign err  = err_q;

endmodule

// File: tb/tb_gpr_scoreboard.sv
// Directed bench for gpr_scoreboard; two instances share stimulus, one with
// writeback bypass and one without, so both hazard timings are observed.
module tb_gpr_scoreboard;

  logic       clk = 1'b0;
  logic       reset, en, issue_valid;
  logic [4:0] gpr_a, gpr_b, gpr_c, gpr_dest_alu, gpr_dest_mem, wb_alu_gpr, wb_mem_gpr;
  logic       read_gpr_a, read_gpr_b, read_gpr_c, write_gpr_dest_alu, write_gpr_dest_mem;
  logic [7:0] read_cr, write_cr, wb_cr;
  logic       read_ctr, write_ctr, read_lnk, write_lnk, read_xer, write_xer;
  logic       wb_alu_valid, wb_mem_valid, wb_ctr, wb_lnk, wb_xer;

  logic ready_b, stall_b, busy_b, err_b;
  logic ready_n, stall_n, busy_n, err_n;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gpr_scoreboard #(.NUM_GPR(32), .NUM_CR(8), .WB_BYPASS(1)) dut (
    .clk(clk), .reset(reset), .en(en), .issue_valid(issue_valid),
    .issue_ready(ready_b), .stall(stall_b),
    .gpr_a(gpr_a), .gpr_b(gpr_b), .gpr_c(gpr_c),
    .read_gpr_a(read_gpr_a), .read_gpr_b(read_gpr_b), .read_gpr_c(read_gpr_c),
    .gpr_dest_alu(gpr_dest_alu), .gpr_dest_mem(gpr_dest_mem),
    .write_gpr_dest_alu(write_gpr_dest_alu), .write_gpr_dest_mem(write_gpr_dest_mem),
    .read_cr(read_cr), .write_cr(write_cr),
    .read_ctr(read_ctr), .write_ctr(write_ctr), .read_lnk(read_lnk),
    .write_lnk(write_lnk), .read_xer(read_xer), .write_xer(write_xer),
    .wb_alu_valid(wb_alu_valid), .wb_alu_gpr(wb_alu_gpr),
    .wb_mem_valid(wb_mem_valid), .wb_mem_gpr(wb_mem_gpr),
    .wb_cr(wb_cr), .wb_ctr(wb_ctr), .wb_lnk(wb_lnk), .wb_xer(wb_xer),
    .busy(busy_b), .err(err_b)
  );

  gpr_scoreboard #(.NUM_GPR(32), .NUM_CR(8), .WB_BYPASS(0)) dut_nb (
    .clk(clk), .reset(reset), .en(en), .issue_valid(issue_valid),
    .issue_ready(ready_n), .stall(stall_n),
    .gpr_a(gpr_a), .gpr_b(gpr_b), .gpr_c(gpr_c),
    .read_gpr_a(read_gpr_a), .read_gpr_b(read_gpr_b), .read_gpr_c(read_gpr_c),
    .gpr_dest_alu(gpr_dest_alu), .gpr_dest_mem(gpr_dest_mem),
    .write_gpr_dest_alu(write_gpr_dest_alu), .write_gpr_dest_mem(write_gpr_dest_mem),
    .read_cr(read_cr), .write_cr(write_cr),
    .read_ctr(read_ctr), .write_ctr(write_ctr), .read_lnk(read_lnk),
    .write_lnk(write_lnk), .read_xer(read_xer), .write_xer(write_xer),
    .wb_alu_valid(wb_alu_valid), .wb_alu_gpr(wb_alu_gpr),
    .wb_mem_valid(wb_mem_valid), .wb_mem_gpr(wb_mem_gpr),
    .wb_cr(wb_cr), .wb_ctr(wb_ctr), .wb_lnk(wb_lnk), .wb_xer(wb_xer),
    .busy(busy_n), .err(err_n)
  );

  // Same-register dual destination is not supported by the scoreboard.
  always @(posedge clk) begin
    if (issue_valid && write_gpr_dest_alu && write_gpr_dest_mem)
      assert (gpr_dest_alu != gpr_dest_mem)
        else $error("unsupported stimulus: both destinations name r%0d", gpr_dest_alu);
  end

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    en = 1'b1; issue_valid = 1'b0;
    gpr_a = '0; gpr_b = '0; gpr_c = '0; gpr_dest_alu = '0; gpr_dest_mem = '0;
    read_gpr_a = 1'b0; read_gpr_b = 1'b0; read_gpr_c = 1'b0;
    write_gpr_dest_alu = 1'b0; write_gpr_dest_mem = 1'b0;
    read_cr = '0; write_cr = '0; wb_cr = '0;
    read_ctr = 1'b0; write_ctr = 1'b0; read_lnk = 1'b0; write_lnk = 1'b0;
    read_xer = 1'b0; write_xer = 1'b0;
    wb_alu_valid = 1'b0; wb_alu_gpr = '0; wb_mem_valid = 1'b0; wb_mem_gpr = '0;
    wb_ctr = 1'b0; wb_lnk = 1'b0; wb_xer = 1'b0;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    issue_valid = 1'b1; read_gpr_a = 1'b1; gpr_a = 5'd3;
    tick(); tick();
    chk("rst_ready", ready_b, 1'b0);
    chk("rst_stall", stall_b, 1'b1);
    chk("rst_busy", busy_b, 1'b0);
    chk("rst_err", err_b, 1'b0);
    reset = 1'b0; #1;
    chk("post_rst_ready_r3", ready_b, 1'b1);
    chk("post_rst_stall", stall_b, 1'b0);
    tick();

    // RAW on r5, bypassed vs non-bypassed release
    idle(); issue_valid = 1'b1; write_gpr_dest_alu = 1'b1; gpr_dest_alu = 5'd5; #1;
    chk("w5_ready", ready_b, 1'b1);
    tick();
    idle(); issue_valid = 1'b1; read_gpr_a = 1'b1; gpr_a = 5'd5; #1;
    chk("raw5_stall", stall_b, 1'b1);
    chk("raw5_stall_nb", stall_n, 1'b1);
    chk("raw5_busy", busy_b, 1'b1);
    wb_alu_valid = 1'b1; wb_alu_gpr = 5'd5; #1;
    chk("raw5_bypass_ready", ready_b, 1'b1);
    chk("raw5_nobypass_stall", stall_n, 1'b1);
    tick();
    wb_alu_valid = 1'b0; #1;
    chk("raw5_nobypass_ready_next", ready_n, 1'b1);
    chk("raw5_busy_clear", busy_b, 1'b0);
    chk("raw5_busy_clear_nb", busy_n, 1'b0);
    chk("raw5_err", err_b, 1'b0);
    tick();

    // WAW on r7 with same-cycle retire and reissue
    idle(); issue_valid = 1'b1; write_gpr_dest_alu = 1'b1; gpr_dest_alu = 5'd7; #1;
    chk("w7_ready", ready_b, 1'b1);
    tick();
    wb_mem_valid = 1'b1; wb_mem_gpr = 5'd7; #1;
    chk("waw7_bypass_ready", ready_b, 1'b1);
    chk("waw7_nobypass_stall", stall_n, 1'b1);
    tick();
    wb_mem_valid = 1'b0; #1;
    chk("waw7_set_dominates_busy", busy_b, 1'b1);
    chk("waw7_nb_busy", busy_n, 1'b0);
    chk("waw7_pending_stall", stall_b, 1'b1);
    chk("waw7_nb_ready", ready_n, 1'b1);
    tick();
    idle(); wb_alu_valid = 1'b1; wb_alu_gpr = 5'd7;
    tick();
    idle(); #1;
    chk("r7_busy_clear", busy_b, 1'b0);
    chk("r7_busy_clear_nb", busy_n, 1'b0);
    chk("r7_err", err_b, 1'b0);
    chk("r7_err_nb", err_n, 1'b0);

    // CR and CTR
    issue_valid = 1'b1; write_cr = 8'h04; write_ctr = 1'b1; #1;
    chk("wcr_ready", ready_b, 1'b1);
    tick();
    idle(); issue_valid = 1'b1; read_cr = 8'h02; #1;
    chk("rcr02_ready", ready_b, 1'b1);
    read_cr = 8'h04; #1;
    chk("rcr04_stall", stall_b, 1'b1);
    read_cr = 8'h00; write_cr = 8'h0c; #1;
    chk("wcr0c_waw_stall", stall_b, 1'b1);
    write_cr = 8'h00; read_ctr = 1'b1; #1;
    chk("rctr_stall", stall_b, 1'b1);
    tick();
    chk("rctr_stall_held", stall_b, 1'b1);
    wb_ctr = 1'b1; #1;
    chk("rctr_wb_bypass_ready", ready_b, 1'b1);
    chk("rctr_wb_nobypass_stall", stall_n, 1'b1);
    tick();
    wb_ctr = 1'b0; #1;
    chk("rctr_nb_ready", ready_n, 1'b1);
    chk("cr_still_busy", busy_b, 1'b1);
    idle(); wb_cr = 8'h04;
    tick();
    idle(); #1;
    chk("cr_busy_clear", busy_b, 1'b0);
    chk("cr_err", err_b, 1'b0);

    // Register 0 is tracked normally
    issue_valid = 1'b1; write_gpr_dest_mem = 1'b1; gpr_dest_mem = 5'd0;
    tick();
    idle(); issue_valid = 1'b1; read_gpr_c = 1'b1; gpr_c = 5'd0; #1;
    chk("r0_raw_stall", stall_b, 1'b1);
    idle(); wb_mem_valid = 1'b1; wb_mem_gpr = 5'd0;
    tick();
    idle(); #1;
    chk("r0_busy_clear", busy_b, 1'b0);

    // Dual-port retire of pending r4
    issue_valid = 1'b1; write_gpr_dest_alu = 1'b1; gpr_dest_alu = 5'd4;
    tick();
    idle(); wb_alu_valid = 1'b1; wb_alu_gpr = 5'd4; wb_mem_valid = 1'b1; wb_mem_gpr = 5'd4;
    tick();
    idle(); issue_valid = 1'b1; read_gpr_b = 1'b1; gpr_b = 5'd4; #1;
    chk("dual_r4_ready", ready_b, 1'b1);
    chk("dual_r4_busy", busy_b, 1'b0);
    chk("dual_r4_err", err_b, 1'b0);
    tick();

    // Writeback to a non-pending register
    idle(); wb_alu_valid = 1'b1; wb_alu_gpr = 5'd9; #1;
    chk("err9_not_yet", err_b, 1'b0);
    tick();
    idle(); #1;
    chk("err9_set", err_b, 1'b1);
    chk("err9_set_nb", err_n, 1'b1);
    chk("err9_busy", busy_b, 1'b0);
    tick(); tick();
    chk("err9_sticky", err_b, 1'b1);

    // en gating
    en = 1'b0; issue_valid = 1'b1; write_gpr_dest_alu = 1'b1; gpr_dest_alu = 5'd10; #1;
    chk("en0_ready", ready_b, 1'b0);
    chk("en0_stall", stall_b, 1'b1);
    tick();
    idle(); #1;
    chk("en0_busy", busy_b, 1'b0);
    issue_valid = 1'b1; read_gpr_a = 1'b1; gpr_a = 5'd10; #1;
    chk("en0_r10_not_set", ready_b, 1'b1);
    tick();

    // Reset mid-operation discards pending state and clears err
    idle(); issue_valid = 1'b1; write_gpr_dest_alu = 1'b1; gpr_dest_alu = 5'd12;
    tick();
    idle(); #1;
    chk("r12_busy", busy_b, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0; #1;
    chk("midrst_busy", busy_b, 1'b0);
    chk("midrst_err", err_b, 1'b0);
    issue_valid = 1'b1; read_gpr_a = 1'b1; gpr_a = 5'd12; #1;
    chk("midrst_r12_ready", ready_b, 1'b1);
    idle(); wb_alu_valid = 1'b1; wb_alu_gpr = 5'd12;
    tick();
    idle(); #1;
    chk("midrst_stale_wb_err", err_b, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
